// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for the iterative multiply/divide unit.
// The master drives requests and consumes results; the slave is the unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a WIDTH-bit
// datapath, valid/ready on both sides, synchronous flush.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi, lo, mag;
  logic             neg_q, spec_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;

  // Request decode: signedness, magnitudes and the no-iteration special cases
  logic             accept;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             b_zero, ovf, special;
  logic [WIDTH-1:0] spec_val;
  logic             neg_in;
  logic [WIDTH-1:0] most_neg;

  assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  assign accept   = bus.in_valid & (state == IDLE) & ~flush;

  assign sign_a = bus.a[WIDTH-1] & ((bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                                    (bus.op == OP_DIV)  | (bus.op == OP_REM));
  assign sign_b = bus.b[WIDTH-1] & ((bus.op == OP_MULH) | (bus.op == OP_DIV) |
                                    (bus.op == OP_REM));
  assign mag_a  = sign_a ? (-bus.a) : bus.a;
  assign mag_b  = sign_b ? (-bus.b) : bus.b;

  assign b_zero   = (bus.b == '0);
  assign ovf      = bus.op[2] & ~bus.op[0] & (bus.a == most_neg) & (bus.b == '1);
  assign special  = bus.op[2] & (b_zero | ovf);
  assign spec_val = b_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
  // Remainder takes the dividend's sign; everything else the sign product
  assign neg_in   = (bus.op[2] & bus.op[1]) ? sign_a : (sign_a ^ sign_b);

  // One shift-add step: hi accumulates, lo shifts the multiplier out
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

  // One restoring-divide step: hi is the partial remainder, lo the quotient
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag});
  assign div_hi_n  = div_ge ? (div_shift[WIDTH-1:0] - mag) : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] hi_n, lo_n;

  assign hi_n = op_q[2] ? div_hi_n : mul_hi_n;
  assign lo_n = op_q[2] ? div_lo_n : mul_lo_n;

  // Sign fix-up and half selection applied to the state after the last step
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   mul_res, quo_s, rem_s, fin;
  logic               last;

  assign prod    = {hi_n, lo_n};
  assign prod_s  = neg_q ? (-prod) : prod;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  assign quo_s   = neg_q ? (-lo_n) : lo_n;
  assign rem_s   = neg_q ? (-hi_n) : hi_n;
  assign fin     = spec_q  ? lo :
                   op_q[2] ? (op_q[1] ? rem_s : quo_s) : mul_res;
  assign last    = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)        state_n = BUSY;
      BUSY:    if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Operand capture and iteration. A special case preloads the counter to its
  // final value so its precomputed result lands one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      mag    <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
    end else if (flush) begin
      cnt    <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      hi     <= '0;
      lo     <= special ? spec_val : (bus.op[2] ? mag_a : mag_b);
      mag    <= bus.op[2] ? mag_b : mag_a;
      neg_q  <= neg_in;
      spec_q <= special;
      cnt    <= special ? CW'(WIDTH - 1) : '0;
    end else if (state == BUSY) begin
      hi     <= hi_n;
      lo     <= lo_n;
      cnt    <= cnt + CW'(1);
    end
  end

  // Registered result side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= (state_n == DONE);
      if ((state == BUSY) && last && !flush) result_q <= fin;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations on a
// 32-bit and an 8-bit instance, checked against an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input bit w8);
    return w8 ? bus8.out_valid : bus32.out_valid;
  endfunction

  function automatic logic get_ready(input bit w8);
    return w8 ? bus8.in_ready : bus32.in_ready;
  endfunction

  function automatic logic [31:0] get_result(input bit w8);
    return w8 ? 32'(bus8.result) : bus32.result;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.in_valid = v; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.in_valid = v; bus32.op = op; bus32.a = a; bus32.b = b;
    end
  endtask

  task automatic set_ordy(input bit w8, input logic r);
    if (w8) bus8.out_ready = r;
    else    bus32.out_ready = r;
  endtask

  // RV32M semantics at width w using plain 64-bit integer arithmetic
  function automatic logic [31:0] ref_res(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub;
    longint sa, sb, r, most_neg;
    bit ovf;
    mask = (64'd1 << w) - 64'd1;
    ua = 64'(a) & mask;
    ub = 64'(b) & mask;
    sa = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
    sb = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
    most_neg = -(longint'(1) << (w - 1));
    ovf = (sa == most_neg) && (sb == -1);
    case (op)
      3'd0: r = longint'(ua * ub);
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * longint'(ub)) >>> w;
      3'd3: r = longint'((ua * ub) >> w);
      3'd4: r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5: r = (ub == 0) ? -1 : longint'(ua / ub);
      3'd6: r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
    endcase
    return 32'($unsigned(r) & mask);
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua = 64'(a) & mask;
    ub = 64'(b) & mask;
    if (op[2] && (ub == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && (ua == (64'd1 << (w - 1))) && (ub == mask)) return 1;
    return w;
  endfunction

  // One full transaction: accept, latency/busy check, result, optional hold, consume
  task automatic run(input string tag, input bit w8, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input int hold);
    int w, cyc;
    bit busy_ok, stable_ok;
    logic [31:0] exp, first;
    w = w8 ? 8 : 32;
    cyc = 0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    exp = ref_res(w, op, a, b);
    @(negedge clk);
    drive(w8, 1'b1, op, a, b);
    set_ordy(w8, 1'b0);
    check({tag, " in_ready_idle"}, 64'(get_ready(w8)), 64'd1);
    @(posedge clk); #1;
    drive(w8, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    while (!get_valid(w8) && cyc < 100) begin
      if (get_ready(w8)) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat(w, op, a, b)));
    check({tag, " in_ready_busy"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, 64'(get_result(w8)), 64'(exp));
    first = get_result(w8);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!get_valid(w8) || get_result(w8) !== first || get_ready(w8)) stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, " hold_stable"}, 64'(stable_ok), 64'd1);
    set_ordy(w8, 1'b1);
    @(posedge clk); #1;
    set_ordy(w8, 1'b0);
    check({tag, " consumed_valid"}, 64'(get_valid(w8)), 64'd0);
    check({tag, " consumed_ready"}, 64'(get_ready(w8)), 64'd1);
  endtask

  task automatic watch_quiet(input string tag, input bit w8, input int cycles);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (get_valid(w8)) quiet = 1'b0;
    end
    check({tag, " no_out_valid"}, 64'(quiet), 64'd1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          cyc;

    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready32", 64'(bus32.in_ready), 64'd1);
    check("reset out_valid32", 64'(bus32.out_valid), 64'd0);
    check("reset result32", 64'(bus32.result), 64'd0);
    check("reset in_ready8", 64'(bus8.in_ready), 64'd1);
    check("reset result8", 64'(bus8.result), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed arithmetic
    run("mul_7x-3",      1'b0, 3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    run("mulh_min2",     1'b0, 3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    run("mulhsu_m1",     1'b0, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run("mulhu_max",     1'b0, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run("divu_100_7",    1'b0, 3'd5, 32'd100,        32'd7,         0);
    run("remu_100_7",    1'b0, 3'd7, 32'd100,        32'd7,         0);
    run("div_m7_2",      1'b0, 3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    run("rem_m7_2",      1'b0, 3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    run("div_5_0",       1'b0, 3'd4, 32'd5,          32'd0,         0);
    run("rem_5_0",       1'b0, 3'd6, 32'd5,          32'd0,         0);
    run("div_ovf",       1'b0, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run("rem_ovf",       1'b0, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);

    // Backpressure for 10 cycles
    run("mul_bp",        1'b0, 3'd1, 32'h1234_5678,  32'h9ABC_DEF0, 10);

    // Flush at iteration 5 of a DIV
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd4, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy out_valid", 64'(bus32.out_valid), 64'd0);
    check("flush_busy in_ready", 64'(bus32.in_ready), 64'd1);
    watch_quiet("flush_busy", 1'b0, 40);
    run("mul_3x4",       1'b0, 3'd0, 32'd3,          32'd4,         0);

    // A request presented together with flush is not taken
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0, 32'd9, 32'd9);
    flush = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    flush = 1'b0;
    check("flush_req in_ready", 64'(bus32.in_ready), 64'd1);
    watch_quiet("flush_req", 1'b0, 36);

    // flush and out_ready together in DONE: flush wins
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    cyc = 0;
    while (!bus32.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("flush_done reached", 64'(bus32.out_valid), 64'd1);
    flush = 1'b1;
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus32.out_ready = 1'b0;
    check("flush_done out_valid", 64'(bus32.out_valid), 64'd0);
    check("flush_done in_ready", 64'(bus32.in_ready), 64'd1);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd1, 32'h7FFF_0001, 32'h0000_0333);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_busy in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    watch_quiet("rst_busy", 1'b0, 40);

    // 8-bit instance
    run("w8 mul_0f_11",  1'b1, 3'd0, 32'h0F, 32'h11, 0);
    run("w8 div_ovf",    1'b1, 3'd4, 32'h80, 32'hFF, 0);
    run("w8 rem_m7_3",   1'b1, 3'd6, 32'hF9, 32'h03, 2);
    run("w8 mulh_min",   1'b1, 3'd1, 32'h80, 32'h80, 0);

    // Random operations on both widths, with occasional special operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      run("rand32", 1'b0, rop, ra, rb, $urandom_range(0, 3));
    end
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 32'($urandom_range(0, 255));
      rb  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80; rb = 32'hFF; end
      run("rand8", 1'b1, rop, ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
